if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32 core. It owns the PC and runs a single-outstanding request/ready handshake to instruction memory. It presents the decode-stage instruction and its `rs1_de`/`rs2_de` fields to the hazard detection unit, and consumes that unit's `HDUStall` (hold) and the EX-stage branch redirect (flush).

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `NOP_INST`, default `32'h0000_0013`: bubble encoding (`addi x0,x0,0`).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `HDUStall`  in  1  load-use stall; hold IF/ID and the PC.
- `br_taken_ex`  in  1  redirect from EX; flushes IF/ID.
- `br_target_ex`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready`  in  1  one-cycle pulse: `imem_rdata` is valid for the current request.
- `imem_rdata`  in  32  instruction word.
- `pc_de`, `pc4_de`, `inst_de`  out  32 each  IF/ID contents.
- `valid_de`  out  1  IF/ID holds a real instruction.
- `rs1_de`, `rs2_de`  out  5 each  `inst_de[19:15]` and `inst_de[24:20]`, combinational.

## Operation
- Internal registers:
  - `pc_f`: next PC to request.
  - `req_addr`: address of the outstanding request; drives `imem_addr`.
  - Skid buffer: `skid_pc`, `skid_inst`.
  - FSM with states FETCH, DROP, HOLD.
- Priority everywhere: `br_taken_ex` > `HDUStall` > normal advance.
- FETCH (`imem_req`=1):
  - `imem_ready`=1 and `br_taken_ex`: discard the response; `pc_f`=`req_addr`=target; IF/ID becomes a bubble; stay in FETCH.
  - `imem_ready`=1 and `HDUStall`: capture the response into the skid buffer; `pc_f`+=4; IF/ID holds; go to HOLD.
  - `imem_ready`=1, otherwise: IF/ID loads {`req_addr`, `req_addr`+4, `imem_rdata`, 1}; `pc_f`=`req_addr`=`req_addr`+4.
  - `imem_ready`=0 and `br_taken_ex`: `pc_f`=target; `req_addr` is unchanged; flush IF/ID; go to DROP.
  - `imem_ready`=0 and `HDUStall`: IF/ID holds.
  - `imem_ready`=0, otherwise: IF/ID becomes a bubble.
- DROP (`imem_req`=1, old address):
  - On `imem_ready`: discard the response; `req_addr`=`pc_f`; go to FETCH.
  - A further `br_taken_ex` in DROP overwrites `pc_f`.
  - IF/ID is a bubble, or holds under `HDUStall`.
- HOLD (`imem_req`=0):
  - `br_taken_ex`: drop the skid buffer; flush IF/ID; `pc_f`=`req_addr`=target; go to FETCH.
  - `HDUStall`=1: hold.
  - `HDUStall`=0: IF/ID loads the skid buffer (valid=1); `req_addr`=`pc_f`; go to FETCH.
- Bubble means `inst_de`=`NOP_INST` and `valid_de`=0; `pc_de` and `pc4_de` keep their values.
- PC arithmetic is modulo 2^32: `32'hFFFF_FFFC`+4 = 0.

## Timing
- Reset values: state FETCH, `pc_f`=`req_addr`=`RESET_PC`, `imem_req`=0 while `rst`=1, `pc_de`=`pc4_de`=0, `inst_de`=`NOP_INST`, `valid_de`=0, skid buffer cleared.
- `imem_req` rises in the first cycle after `rst` deasserts.
- `imem_ready` may assert in the same cycle `imem_req` rises (zero-wait memory). This sustains one instruction per cycle.
- IF/ID updates on the edge where `imem_ready` is sampled high. `inst_de` is visible in the following cycle.
- Redirect penalty:
  - Zero-wait memory: the target is requested in the cycle after `br_taken_ex`.
  - Pending request: the target is requested in the cycle after the old response drains.
- Reset mid-operation: an outstanding request is abandoned. Memory must ignore stale `imem_req` state after reset.

## Configuration
- `STALL_PERF_EN` defined:
  - Adds port `perf_stall_cnt` (out, 32), reset to 0.
  - Increments each cycle `HDUStall`=1 and saturates at `32'hFFFF_FFFF`.
- `STALL_PERF_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- `pipeline_pkg` holds:
  - `NOP_INST_C`.
  - `fetch_state_e` (FETCH, DROP, HOLD).
  - Packed struct `if_id_t` {pc, pc4, inst, valid}.
- Sub-module `if_id_reg`: the IF/ID register with load, hold and bubble controls. The FSM, PC and skid buffer live in the top module.

## Test plan
- Zero-wait memory, `imem_rdata`=`32'h0010_0093` at 0: after reset, `pc_de`=0, `inst_de`=`32'h0010_0093`, `valid_de`=1 one cycle after `imem_req` rises; next PC 4.
- `HDUStall` pulsed 2 cycles while PC 8 returns: IF/ID holds PC 4 for 2 cycles, then PC 8 loads; no address is skipped or repeated.
- 3-wait memory, `br_taken_ex` with target `32'h0000_0100` during the wait: old response discarded, `imem_addr`=`32'h100` next; `valid_de`=0 until it returns.
- `br_taken_ex` and `HDUStall` in the same cycle in HOLD: skid dropped, IF/ID bubble, fetch from target.
- `RESET_PC`=`32'hFFFF_FFFC`: second request address 0.
- With `STALL_PERF_EN`: 5 stall cycles give `perf_stall_cnt`=5; asserting `rst` mid-stream returns every output to its reset value.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the pipelined RV32 core front end: the bubble encoding,
// the fetch FSM states and the IF/ID register layout.
package pipeline_pkg;

    localparam logic [31:0] NOP_INST_C = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: bubble > hold > load; with no control
// asserted the contents are kept. A bubble keeps pc/pc4 and inserts NOP_INST.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '{pc: 32'd0, pc4: 32'd0, inst: NOP_INST, valid: 1'b0};
        end else if (bubble) begin
            q_reg.inst  <= NOP_INST;
            q_reg.valid <= 1'b0;
        end else if (hold) begin
            q_reg <= q_reg;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch with a single-outstanding imem handshake plus the IF/ID
// register. Optional stall counter output enabled by defining STALL_PERF_EN.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HDUStall,
    input  logic        br_taken_ex,
    input  logic [31:0] br_target_ex,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_de,
    output logic [31:0] pc4_de,
    output logic [31:0] inst_de,
    output logic        valid_de,
`ifdef STALL_PERF_EN
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [4:0]  rs1_de,
    output logic [4:0]  rs2_de
);

    fetch_state_e state_reg;
    logic [31:0]  pc_f_reg;
    logic [31:0]  req_addr_reg;
    logic [31:0]  skid_pc_reg;
    logic [31:0]  skid_inst_reg;
    logic [31:0]  br_target;
    logic [31:0]  req_addr_inc;

    logic   ifid_load;
    logic   ifid_hold;
    logic   ifid_bubble;
    if_id_t ifid_d;
    if_id_t ifid_q;

    assign br_target    = {br_target_ex[31:2], 2'b00};
    assign req_addr_inc = req_addr_reg + 32'd4;

    // HOLD parks the fetch with the response already in the skid buffer.
    assign imem_req  = !rst && (state_reg != HOLD);
    assign imem_addr = req_addr_reg;

    always_comb begin
        ifid_load   = 1'b0;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = '{pc: req_addr_reg, pc4: req_addr_inc, inst: imem_rdata, valid: 1'b1};
        case (state_reg)
            FETCH: begin
                if (br_taken_ex)     ifid_bubble = 1'b1;
                else if (HDUStall)   ifid_hold   = 1'b1;
                else if (imem_ready) ifid_load   = 1'b1;
                else                 ifid_bubble = 1'b1;
            end
            DROP: begin
                if (br_taken_ex)     ifid_bubble = 1'b1;
                else if (HDUStall)   ifid_hold   = 1'b1;
                else                 ifid_bubble = 1'b1;
            end
            HOLD: begin
                if (br_taken_ex) begin
                    ifid_bubble = 1'b1;
                end else if (HDUStall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    ifid_d    = '{pc: skid_pc_reg, pc4: skid_pc_reg + 32'd4,
                                  inst: skid_inst_reg, valid: 1'b1};
                end
            end
            default: ifid_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FETCH;
            pc_f_reg      <= RESET_PC;
            req_addr_reg  <= RESET_PC;
            skid_pc_reg   <= 32'd0;
            skid_inst_reg <= 32'd0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        if (br_taken_ex) begin
                            pc_f_reg     <= br_target;
                            req_addr_reg <= br_target;
                        end else if (HDUStall) begin
                            skid_pc_reg   <= req_addr_reg;
                            skid_inst_reg <= imem_rdata;
                            pc_f_reg      <= req_addr_inc;
                            state_reg     <= HOLD;
                        end else begin
                            pc_f_reg     <= req_addr_inc;
                            req_addr_reg <= req_addr_inc;
                        end
                    end else if (br_taken_ex) begin
                        // The old request must still drain; remember where to go next.
                        pc_f_reg  <= br_target;
                        state_reg <= DROP;
                    end
                end
                DROP: begin
                    if (br_taken_ex) pc_f_reg <= br_target;
                    if (imem_ready) begin
                        req_addr_reg <= br_taken_ex ? br_target : pc_f_reg;
                        state_reg    <= FETCH;
                    end
                end
                HOLD: begin
                    if (br_taken_ex) begin
                        pc_f_reg      <= br_target;
                        req_addr_reg  <= br_target;
                        skid_pc_reg   <= 32'd0;
                        skid_inst_reg <= 32'd0;
                        state_reg     <= FETCH;
                    end else if (!HDUStall) begin
                        req_addr_reg <= pc_f_reg;
                        state_reg    <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (ifid_load),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign pc_de    = ifid_q.pc;
    assign pc4_de   = ifid_q.pc4;
    assign inst_de  = ifid_q.inst;
    assign valid_de = ifid_q.valid;
    assign rs1_de   = ifid_q.inst[19:15];
    assign rs2_de   = ifid_q.inst[24:20];

`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= 32'd0;
        end else if (HDUStall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: zero-wait streaming, stall/skid, redirects
// in FETCH/DROP/HOLD, PC wrap-around and reset mid-stream.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        HDUStall;
    logic        br_taken_ex;
    logic [31:0] br_target_ex;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_de, pc4_de, inst_de;
    logic        valid_de;
    logic [4:0]  rs1_de, rs2_de;
`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_stall_cnt_w;
`endif

    // second instance for the wrap-around reset PC
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc, w_pc4, w_inst;
    logic        w_valid;
    logic [4:0]  w_rs1, w_rs2;

    int errors = 0;
    int checks = 0;
    int wait_cfg = 0;
    int wcnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0010_0093;
        return {a[19:0], 12'h013};
    endfunction

    // memory model: ready after wait_cfg idle cycles of a request
    assign imem_ready = imem_req && (wcnt >= wait_cfg);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst)                  wcnt <= 0;
        else if (!imem_req)       wcnt <= 0;
        else if (imem_ready)      wcnt <= 0;
        else                      wcnt <= wcnt + 1;
    end

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .HDUStall     (HDUStall),
        .br_taken_ex  (br_taken_ex),
        .br_target_ex (br_target_ex),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc_de        (pc_de),
        .pc4_de       (pc4_de),
        .inst_de      (inst_de),
        .valid_de     (valid_de),
`ifdef STALL_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .rs1_de       (rs1_de),
        .rs2_de       (rs2_de)
    );

    if_id_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .HDUStall     (1'b0),
        .br_taken_ex  (1'b0),
        .br_target_ex (32'd0),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_ready   (w_req),
        .imem_rdata   (32'h0000_0013),
        .pc_de        (w_pc),
        .pc4_de       (w_pc4),
        .inst_de      (w_inst),
        .valid_de     (w_valid),
`ifdef STALL_PERF_EN
        .perf_stall_cnt (perf_stall_cnt_w),
`endif
        .rs1_de       (w_rs1),
        .rs2_de       (w_rs2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, ".addr"},  imem_addr, 32'd0);
        chk({tag, ".pc"},    pc_de, 32'd0);
        chk({tag, ".pc4"},   pc4_de, 32'd0);
        chk({tag, ".inst"},  inst_de, 32'h0000_0013);
        chk({tag, ".valid"}, {31'd0, valid_de}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; HDUStall = 1'b0; br_taken_ex = 1'b0; br_target_ex = 32'd0;
        @(negedge clk); @(negedge clk);
        chk_reset_outputs("rst");
        chk("wrap.rst_addr", w_addr, 32'hFFFF_FFFC);

        // zero-wait streaming
        rst = 1'b0; #1;
        chk("req_rise", {31'd0, imem_req}, 32'd1);
        step();
        chk("s0.pc",    pc_de, 32'd0);
        chk("s0.inst",  inst_de, 32'h0010_0093);
        chk("s0.valid", {31'd0, valid_de}, 32'd1);
        chk("s0.pc4",   pc4_de, 32'd4);
        chk("s0.rs1",   {27'd0, rs1_de}, 32'd0);
        chk("s0.rs2",   {27'd0, rs2_de}, 32'd1);
        chk("s0.addr",  imem_addr, 32'd4);
        chk("wrap.addr2", w_addr, 32'd0);
        step();
        chk("s1.pc",    pc_de, 32'd4);
        chk("s1.inst",  inst_de, 32'h0000_4013);
        chk("s1.addr",  imem_addr, 32'd8);

        // stall 2 cycles while PC 8 returns
        HDUStall = 1'b1;
        step();
        chk("st1.pc",   pc_de, 32'd4);
        chk("st1.req",  {31'd0, imem_req}, 32'd0);
        step();
        chk("st2.pc",   pc_de, 32'd4);
        chk("st2.valid", {31'd0, valid_de}, 32'd1);
        HDUStall = 1'b0;
        step();
        chk("st3.pc",   pc_de, 32'd8);
        chk("st3.inst", inst_de, 32'h0000_8013);
        chk("st3.addr", imem_addr, 32'd12);
        step();
        chk("st4.pc",   pc_de, 32'd12);
        chk("st4.addr", imem_addr, 32'd16);

        // branch + stall together while in HOLD
        HDUStall = 1'b1;
        step();
        chk("h0.req",   {31'd0, imem_req}, 32'd0);
        br_taken_ex = 1'b1; br_target_ex = 32'h0000_0203;
        step();
        chk("h1.valid", {31'd0, valid_de}, 32'd0);
        chk("h1.inst",  inst_de, 32'h0000_0013);
        chk("h1.pc",    pc_de, 32'd12);
        chk("h1.addr",  imem_addr, 32'h0000_0200);
        chk("h1.req",   {31'd0, imem_req}, 32'd1);
        br_taken_ex = 1'b0; HDUStall = 1'b0;
        step();
        chk("h2.pc",    pc_de, 32'h0000_0200);
        chk("h2.inst",  inst_de, 32'h0020_0013);
        chk("h2.valid", {31'd0, valid_de}, 32'd1);

        // 3-wait memory, branch while the request is pending
        wait_cfg = 3;
        step();
        chk("w0.valid", {31'd0, valid_de}, 32'd0);
        chk("w0.pc",    pc_de, 32'h0000_0200);
        br_taken_ex = 1'b1; br_target_ex = 32'h0000_0100;
        step();
        br_taken_ex = 1'b0;
        chk("w1.addr",  imem_addr, 32'h0000_0204);
        chk("w1.valid", {31'd0, valid_de}, 32'd0);
        step();
        step();
        chk("w2.addr",  imem_addr, 32'h0000_0100);
        chk("w2.inst",  inst_de, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("w3.valid", {31'd0, valid_de}, 32'd0);
        end
        step();
        chk("w4.valid", {31'd0, valid_de}, 32'd1);
        chk("w4.pc",    pc_de, 32'h0000_0100);
        chk("w4.inst",  inst_de, 32'h0010_0013);

        // zero-wait redirect
        wait_cfg = 0;
        step();
        chk("z0.pc", pc_de, 32'h0000_0104);
        br_taken_ex = 1'b1; br_target_ex = 32'h0000_0040;
        step();
        br_taken_ex = 1'b0;
        chk("z1.addr",  imem_addr, 32'h0000_0040);
        chk("z1.valid", {31'd0, valid_de}, 32'd0);
        step();
        chk("z2.pc",    pc_de, 32'h0000_0040);

        // reset mid-stream
        rst = 1'b1; #1;
        chk_reset_outputs("mid");
        @(negedge clk);
        rst = 1'b0;
`ifdef STALL_PERF_EN
        chk("perf0", perf_stall_cnt, 32'd0);
        HDUStall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        HDUStall = 1'b0;
        chk("perf5", perf_stall_cnt, 32'd5);
        step();
        chk("perf5h", perf_stall_cnt, 32'd5);
        rst = 1'b1; #1;
        chk("perf_rst", perf_stall_cnt, 32'd0);
        chk_reset_outputs("rst2");
        @(negedge clk);
        rst = 1'b0;
`endif
        step();
        chk("post.pc",   pc_de, 32'd0);
        chk("post.inst", inst_de, 32'h0010_0093);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
